div_param: RTL and testbench



---
 rtl/div_pkg.sv | 16 +
 rtl/div_param_step.sv | 36 +++
 rtl/div_param.sv | 141 ++++++++++++++
 tb/tb_div_param.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the parametrised multicycle divider.
//   state_t  : controller states (IDLE, CALC, FIX)
//   N_REM    : bit of the custom-instruction n field selecting remainder output
//   N_SIGNED : bit of the n field selecting two's complement operation
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    localparam int N_REM    = 0;
    localparam int N_SIGNED = 1;

endpackage

// File: rtl/div_param_step.sv
// One restoring shift-subtract iteration (purely combinational).
// Ports:
//   rem      in  WIDTH+1  current partial remainder
//   q        in  WIDTH    dividend bits still to shift in / quotient bits so far
//   divisor  in  WIDTH    divisor magnitude
//   rem_next out WIDTH+1  partial remainder after this iteration
//   q_next   out WIDTH    q shifted left with the new quotient bit inserted
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // The partial remainder always stays below the divisor, so its top bit is
    // zero; carrying it into the subtraction keeps the borrow test exact and
    // makes the top bit of trial a clean sign.
    always_comb begin
        shifted = {rem, q[WIDTH-1]};
        trial   = shifted - {2'b00, divisor};
        if (!trial[WIDTH+1]) begin
            rem_next = trial[WIDTH:0];
            q_next   = {q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH:0];
            q_next   = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_param.sv
// Parametrised multicycle integer divider for a custom-instruction slot.
// Fixed WIDTH+2 enabled-cycle latency, one quotient bit per enabled cycle,
// back-to-back issue (start accepted on the edge that clears done).
// Ports:
//   clk     in  1      system clock
//   reset   in  1      synchronous active-high reset
//   clk_en  in  1      clock enable; when low every register holds
//   start   in  1      operation request, sampled in IDLE only
//   dataa   in  WIDTH  dividend
//   datab   in  WIDTH  divisor
//   n       in  2      n[0]: 0 quotient / 1 remainder; n[1]: 0 unsigned / 1 signed
//   result  out WIDTH  selected result, held until the next completion
//   done    out 1      one-enabled-cycle completion strobe
module div_param
    import div_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    input  logic [1:0]       n,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_reg;
    logic               rem_sel_reg;
    logic               sa_reg;
    logic               sb_reg;
    logic               div0_reg;
    logic [WIDTH-1:0]   divisor_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH:0]     rem_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               done_reg;

    logic               sa_next;
    logic               sb_next;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     rem_step;
    logic [WIDTH-1:0]   q_step;
    logic [WIDTH-1:0]   rem_low;
    logic [WIDTH-1:0]   quot_final;
    logic [WIDTH-1:0]   rem_final;

    // Operand magnitudes. Negating the most-negative value wraps back to
    // 2^(WIDTH-1), which is exactly its magnitude read as unsigned.
    always_comb begin
        sa_next = n[N_SIGNED] & dataa[WIDTH-1];
        sb_next = n[N_SIGNED] & datab[WIDTH-1];
        a_mag   = sa_next ? (~dataa + 1'b1) : dataa;
        b_mag   = sb_next ? (~datab + 1'b1) : datab;
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem      (rem_reg),
        .q        (q_reg),
        .divisor  (divisor_reg),
        .rem_next (rem_step),
        .q_next   (q_step)
    );

    // Sign fix-up. With a zero divisor every trial succeeds, so the magnitude
    // quotient is all ones and the remainder is |dataa|; re-applying the
    // dividend sign restores dataa exactly. Only the quotient needs an
    // override, otherwise a negative dividend would flip it to +1.
    always_comb begin
        rem_low    = rem_reg[WIDTH-1:0];
        quot_final = (sa_reg ^ sb_reg) ? (~q_reg + 1'b1) : q_reg;
        if (div0_reg) begin
            quot_final = '1;
        end
        rem_final  = sa_reg ? (~rem_low + 1'b1) : rem_low;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            rem_sel_reg <= 1'b0;
            sa_reg      <= 1'b0;
            sb_reg      <= 1'b0;
            div0_reg    <= 1'b0;
            divisor_reg <= '0;
            q_reg       <= '0;
            rem_reg     <= '0;
            cnt_reg     <= '0;
            result_reg  <= '0;
            done_reg    <= 1'b0;
        end else if (clk_en) begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        // Only the output-select bit is needed later; the
                        // signed bit is fully captured by sa/sb.
                        rem_sel_reg <= n[N_REM];
                        sa_reg      <= sa_next;
                        sb_reg      <= sb_next;
                        div0_reg    <= (datab == '0);
                        divisor_reg <= b_mag;
                        q_reg       <= a_mag;
                        rem_reg     <= '0;
                        cnt_reg     <= '0;
                        state_reg   <= CALC;
                    end
                end
                CALC: begin
                    rem_reg <= rem_step;
                    q_reg   <= q_step;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_ITER) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    result_reg <= rem_sel_reg ? rem_final : quot_final;
                    done_reg   <= 1'b1;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign result = result_reg;
    assign done   = done_reg;

endmodule

// File: tb/tb_div_param.sv
module tb_div_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;

    logic        start32;
    logic [31:0] a32, b32, res32;
    logic [1:0]  n32;
    logic        done32;

    logic        start8;
    logic [7:0]  a8, b8, res8;
    logic [1:0]  n8;
    logic        done8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_param #(.WIDTH(32)) dut32 (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start32),
        .dataa  (a32),
        .datab  (b32),
        .n      (n32),
        .result (res32),
        .done   (done32)
    );

    div_param #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start8),
        .dataa  (a8),
        .datab  (b8),
        .n      (n8),
        .result (res8),
        .done   (done8)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  n;
        logic [31:0] expv;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: plain integer arithmetic, truncating toward zero.
    function automatic logic [31:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic [1:0] nn);
        longint mask, ua, ub, sa, sb, q, r, half, full;
        full = longint'(1) << w;
        half = longint'(1) << (w - 1);
        mask = full - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        if (ub == 0) begin
            q = mask;
            r = ua;
        end else if (nn[1]) begin
            sa = (ua >= half) ? ua - full : ua;
            sb = (ub >= half) ? ub - full : ub;
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        return nn[0] ? 32'(r & mask) : 32'(q & mask);
    endfunction

    // Caller must be at a negedge. Returns at the negedge where done is seen.
    // freeze_at: clock count after which clk_en is dropped for 10 cycles.
    // pulse_at : enabled-edge count at which a junk start is pulsed.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] nn, input int freeze_at, input int pulse_at,
                          output logic [31:0] res, output int lat, output int cyc,
                          output bit to);
        if (w == 32) begin
            a32 = a; b32 = b; n32 = nn; start32 = 1'b1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; n8 = nn; start8 = 1'b1;
        end
        lat = 0; cyc = 0; to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            cyc++;
            if (clk_en) lat++;
            @(negedge clk);
            start32 = 1'b0;
            start8  = 1'b0;
            if (lat == pulse_at) begin
                if (w == 32) begin
                    a32 = 32'd7; b32 = 32'd1; n32 = 2'b01; start32 = 1'b1;
                end else begin
                    a8 = 8'd7; b8 = 8'd1; n8 = 2'b01; start8 = 1'b1;
                end
            end
            if (cyc == freeze_at) clk_en = 1'b0;
            if (freeze_at > 0 && cyc == freeze_at + 10) clk_en = 1'b1;
            if ((w == 32) ? done32 : done8) begin
                to = 1'b0;
                break;
            end
        end
        res = (w == 32) ? res32 : {24'd0, res8};
        $display("op w=%0d a=%h b=%h n=%b res=%h lat=%0d cyc=%0d", w, a, b, nn, res, lat, cyc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res, a, b;
        logic [1:0]  nn;
        int          lat, cyc, r;
        bit          to, seen;

        vecs[0]  = '{32'd100,        32'd7,          2'b00, 32'd14};
        vecs[1]  = '{32'd100,        32'd7,          2'b01, 32'd2};
        vecs[2]  = '{32'hFFFFFF9C,   32'd7,          2'b10, 32'hFFFFFFF2};
        vecs[3]  = '{32'hFFFFFF9C,   32'd7,          2'b11, 32'hFFFFFFFE};
        vecs[4]  = '{32'd100,        32'hFFFFFFF9,   2'b11, 32'd2};
        vecs[5]  = '{32'd5,          32'd0,          2'b00, 32'hFFFFFFFF};
        vecs[6]  = '{32'd5,          32'd0,          2'b10, 32'hFFFFFFFF};
        vecs[7]  = '{32'd5,          32'd0,          2'b01, 32'd5};
        vecs[8]  = '{32'h80000000,   32'hFFFFFFFF,   2'b10, 32'h80000000};
        vecs[9]  = '{32'h80000000,   32'hFFFFFFFF,   2'b11, 32'd0};
        vecs[10] = '{32'hFFFFFFFB,   32'd0,          2'b11, 32'hFFFFFFFB};

        reset = 1'b1; clk_en = 1'b1;
        start32 = 1'b0; a32 = '0; b32 = '0; n32 = '0;
        start8  = 1'b0; a8  = '0; b8  = '0; n8  = '0;
        repeat (3) @(negedge clk);
        check("reset_done32", done32, 0);
        check("reset_res32", res32, 0);
        check("reset_done8", done8, 0);
        check("reset_res8", res8, 0);
        reset = 1'b0;

        // Directed table, issued back to back on each done cycle.
        for (int i = 0; i < 11; i++) begin
            run_op(32, vecs[i].a, vecs[i].b, vecs[i].n, -1, -1, res, lat, cyc, to);
            check($sformatf("vec%0d_timeout", i), to, 0);
            check($sformatf("vec%0d_result", i), res, vecs[i].expv);
            check($sformatf("vec%0d_model", i), res, model(32, vecs[i].a, vecs[i].b, vecs[i].n));
            check($sformatf("vec%0d_latency", i), lat, 34);
        end

        // done held while clk_en is low, then cleared by the next enabled edge.
        clk_en = 1'b0;
        repeat (3) @(negedge clk);
        check("frozen_done", done32, 1);
        check("frozen_result", res32, 32'hFFFFFFFB);
        clk_en = 1'b1;
        @(negedge clk);
        check("done_one_cycle", done32, 0);

        // clk_en low for 10 cycles mid-CALC.
        run_op(32, 32'd100, 32'd7, 2'b00, 12, -1, res, lat, cyc, to);
        check("freeze_timeout", to, 0);
        check("freeze_result", res, 14);
        check("freeze_latency", lat, 34);
        check("freeze_cycles", cyc, 44);

        // start pulse during CALC is ignored.
        run_op(32, 32'd1000, 32'd10, 2'b00, -1, 8, res, lat, cyc, to);
        check("pulse_timeout", to, 0);
        check("pulse_result", res, 100);
        check("pulse_latency", lat, 34);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i > 0 && done32) seen = 1'b1;
        end
        check("pulse_no_second_done", seen, 0);

        // Reset in the middle of an operation.
        a32 = 32'd1000; b32 = 32'd3; n32 = 2'b00; start32 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            start32 = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_done", done32, 0);
        check("midreset_result", res32, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done32) seen = 1'b1;
        end
        check("midreset_no_done", seen, 0);
        run_op(32, 32'd1000, 32'd3, 2'b01, -1, -1, res, lat, cyc, to);
        check("after_reset_result", res, 1);
        check("after_reset_latency", lat, 34);

        // Randomised, WIDTH=32.
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            r = $urandom_range(0, 9);
            b = (r == 0) ? 32'd0 : (r == 1) ? 32'hFFFFFFFF : (r == 2) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            nn = 2'($urandom_range(0, 3));
            run_op(32, a, b, nn, -1, -1, res, lat, cyc, to);
            check($sformatf("rnd32_%0d_result", i), res, model(32, a, b, nn));
            check($sformatf("rnd32_%0d_latency", i), lat, 34);
        end

        // Narrow instance.
        @(negedge clk);
        run_op(8, 32'd200, 32'd3, 2'b00, -1, -1, res, lat, cyc, to);
        check("w8_quot", res, 66);
        check("w8_latency", lat, 10);
        run_op(8, 32'd200, 32'd3, 2'b01, -1, -1, res, lat, cyc, to);
        check("w8_rem", res, 2);
        check("w8_rem_latency", lat, 10);
        for (int i = 0; i < 25; i++) begin
            a = 32'($urandom_range(0, 255));
            r = $urandom_range(0, 5);
            b = (r == 0) ? 32'd0 : (r == 1) ? 32'hFF : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) a = 32'h80;
            nn = 2'($urandom_range(0, 3));
            run_op(8, a, b, nn, -1, -1, res, lat, cyc, to);
            check($sformatf("rnd8_%0d_result", i), res, model(8, a, b, nn));
            check($sformatf("rnd8_%0d_latency", i), lat, 10);
        end
        @(negedge clk);
        check("w8_done_one_cycle", done8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
